// File: rtl/core_ctrl.sv
// -----------------------------------------------------------------------------
// core_ctrl
//   Instruction sequencer placed directly upstream of the core. A single start
//   pulse runs one convolution tile over NKIJ kernel positions. Each position
//   goes through five phases: weight load into L0, kernel push into the array,
//   activation load into L0, execute, and OFIFO drain into psum memory. Drains
//   after the first position use read-modify-write pairs so the core
//   accumulates partial sums.
//
// Ports
//   clk          in   1  single clock, rising edge
//   reset        in   1  synchronous, active-high
//   start        in   1  one-cycle tile request, honoured only in IDLE
//   kernel_base  in  11  xmem address of the kij=0 weights (latched at start)
//   act_base     in  11  xmem address of the activations (latched at start)
//   psum_base    in  11  pmem address of the output tile (latched at start)
//   ofifo_valid  in   1  core OFIFO holds a readable row
//   inst         out 35  registered instruction word to the core
//   busy         out  1  tile in progress
//   done         out  1  one-cycle pulse after the last drain write
//
// Configuration
//   CORE_CTRL_RELU_EN  when defined, inst[34] (relu_valid) is raised on every
//                      drain write of the final kernel position; otherwise it
//                      is tied to 0.
// -----------------------------------------------------------------------------
module core_ctrl #(
    parameter int COL  = 8,
    parameter int LEN  = 36,
    parameter int NKIJ = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] kernel_base,
    input  logic [10:0] act_base,
    input  logic [10:0] psum_base,
    input  logic        ofifo_valid,
    output logic [34:0] inst,
    output logic        busy,
    output logic        done
);

    localparam int CMAX  = (COL > LEN) ? COL : LEN;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam int KIJ_W = (NKIJ > 1) ? $clog2(NKIJ) : 1;

    localparam logic [CNT_W-1:0] COL_C    = CNT_W'(COL);
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LAST_M   = CNT_W'(LEN - 1);
    localparam logic [KIJ_W-1:0] LAST_KIJ = KIJ_W'(NKIJ - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KLOAD, S_KPUSH, S_ALOAD, S_EXEC, S_DRAIN, S_DONE
    } state_e;

    typedef struct packed {
        logic        relu;
        logic        accum;
        logic        p_cen_n;
        logic        p_wen_n;
        logic [10:0] p_addr;
        logic        x_cen_n;
        logic        x_wen_n;
        logic [10:0] x_addr;   // bit 10 is the l0/ififo select, always 0 here
        logic        ofifo_rd;
        logic [1:0]  rsvd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load_kernel;
    } inst_t;

    // Both memories deselected and in read mode; everything else off.
    localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_ph_q, wr_ph_d;   // second half of a read+write pair
    logic [KIJ_W-1:0]   kij_q, kij_d;
    logic [9:0]         kbase_q, kbase_d;
    logic [9:0]         abase_q, abase_d;
    logic [10:0]        pbase_q, pbase_d;
    logic [34:0]        inst_q;
    logic               busy_q, done_q;

    inst_t              w;
    logic               busy_d, done_d;
    logic [9:0]         kij_off;
    logic               do_rd, do_wr;

    // Bit 10 of the xmem bases is dropped: generated xmem addresses are 10-bit.
    logic unused_base_msb;
    assign unused_base_msb = kernel_base[10] ^ act_base[10];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_ph_q <= 1'b0;
            kij_q   <= '0;
            kbase_q <= '0;
            abase_q <= '0;
            pbase_q <= '0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_ph_q <= wr_ph_d;
            kij_q   <= kij_d;
            kbase_q <= kbase_d;
            abase_q <= abase_d;
            pbase_q <= pbase_d;
            inst_q  <= w;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_ph_d = wr_ph_q;
        kij_d   = kij_q;
        kbase_d = kbase_q;
        abase_d = abase_q;
        pbase_d = pbase_q;
        w       = inst_t'(IDLE_WORD);
        busy_d  = 1'b1;
        done_d  = 1'b0;
        do_rd   = 1'b0;
        do_wr   = 1'b0;
        kij_off = 10'(int'(kij_q) * COL);

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    kbase_d = kernel_base[9:0];
                    abase_d = act_base[9:0];
                    pbase_d = psum_base;
                    kij_d   = '0;
                    cnt_d   = '0;
                    wr_ph_d = 1'b0;
                    state_d = S_KLOAD;
                end
            end

            // SRAM read latency is one cycle, so l0_wr trails the read by one
            // and the phase runs one cycle longer than the word count.
            S_KLOAD: begin
                if (cnt_q != COL_C) begin
                    w.x_cen_n = 1'b0;
                    w.x_addr  = {1'b0, kbase_q + kij_off + 10'(cnt_q)};
                end
                w.l0_wr = (cnt_q != '0);
                if (cnt_q == COL_C) begin
                    cnt_d   = '0;
                    state_d = S_KPUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_KPUSH: begin
                if (cnt_q != COL_C) begin
                    w.l0_rd       = 1'b1;
                    w.load_kernel = 1'b1;
                    cnt_d         = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_ALOAD;
                end
            end

            S_ALOAD: begin
                if (cnt_q != LEN_C) begin
                    w.x_cen_n = 1'b0;
                    w.x_addr  = {1'b0, abase_q + 10'(cnt_q)};
                end
                w.l0_wr = (cnt_q != '0);
                if (cnt_q == LEN_C) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_EXEC: begin
                if (cnt_q != LEN_C) begin
                    w.l0_rd   = 1'b1;
                    w.execute = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    wr_ph_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end

            // ofifo_valid only matters at a word boundary; once a read has
            // been issued its write follows unconditionally.
            S_DRAIN: begin
                if (wr_ph_q) begin
                    do_wr = 1'b1;
                end else if (ofifo_valid) begin
                    if (kij_q == '0) do_wr = 1'b1;
                    else             do_rd = 1'b1;
                end

                if (do_rd || do_wr) begin
                    w.p_cen_n = 1'b0;
                    w.p_addr  = pbase_q + 11'(cnt_q);
                    w.accum   = (kij_q != '0);
                end
                if (do_rd) wr_ph_d = 1'b1;
                if (do_wr) begin
                    w.p_wen_n  = 1'b0;
                    w.ofifo_rd = 1'b1;
                    wr_ph_d    = 1'b0;
`ifdef CORE_CTRL_RELU_EN
                    w.relu = (kij_q == LAST_KIJ);
`else
                    w.relu = 1'b0;
`endif
                    if (cnt_q == LAST_M) begin
                        cnt_d = '0;
                        if (kij_q == LAST_KIJ) begin
                            state_d = S_DONE;
                        end else begin
                            kij_d   = kij_q + 1'b1;
                            state_d = S_KLOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_ctrl
//   Self-checking bench for core_ctrl. The expected instruction stream for a
//   whole tile is generated from the instruction map and queued when the tile
//   is started; each registered output word is popped and compared.
// -----------------------------------------------------------------------------
module tb_core_ctrl;

    localparam int COL    = 8;
    localparam int LEN    = 36;
    localparam int NKIJ   = 9;
    localparam int DRAIN0 = 2 * (COL + 1) + 2 * (LEN + 1);   // first kij=0 drain word
    localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] kernel_base;
    logic [10:0] act_base;
    logic [10:0] psum_base;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    core_ctrl #(.COL(COL), .LEN(LEN), .NKIJ(NKIJ)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .kernel_base (kernel_base),
        .act_base    (act_base),
        .psum_base   (psum_base),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [34:0] exp_q[$];
    logic [34:0] obs[$];
    int          done_at;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full expected word stream of one tile, ending with the done-cycle word.
    task automatic build_expected(input logic [10:0] kb, input logic [10:0] ab,
                                  input logic [10:0] pb, input int stall_m,
                                  input int stall_len);
        logic [34:0] w;
        logic [9:0]  xa;
        logic [10:0] pa;
        bit          relu_build;
`ifdef CORE_CTRL_RELU_EN
        relu_build = 1'b1;
`else
        relu_build = 1'b0;
`endif
        for (int kij = 0; kij < NKIJ; kij++) begin
            for (int k = 0; k <= COL; k++) begin
                w = IDLE_W;
                if (k < COL) begin
                    xa       = kb[9:0] + 10'(kij * COL + k);
                    w[19]    = 1'b0;
                    w[17:7]  = {1'b0, xa};
                end
                if (k > 0) w[2] = 1'b1;
                exp_q.push_back(w);
            end
            for (int k = 0; k <= COL; k++) begin
                w = IDLE_W;
                if (k < COL) begin w[3] = 1'b1; w[0] = 1'b1; end
                exp_q.push_back(w);
            end
            for (int k = 0; k <= LEN; k++) begin
                w = IDLE_W;
                if (k < LEN) begin
                    xa      = ab[9:0] + 10'(k);
                    w[19]   = 1'b0;
                    w[17:7] = {1'b0, xa};
                end
                if (k > 0) w[2] = 1'b1;
                exp_q.push_back(w);
            end
            for (int k = 0; k <= LEN; k++) begin
                w = IDLE_W;
                if (k < LEN) begin w[3] = 1'b1; w[1] = 1'b1; end
                exp_q.push_back(w);
            end
            for (int m = 0; m < LEN; m++) begin
                if (kij == 0 && m == stall_m)
                    for (int s = 0; s < stall_len; s++) exp_q.push_back(IDLE_W);
                pa = pb + 11'(m);
                if (kij > 0) begin
                    w        = IDLE_W;
                    w[32]    = 1'b0;
                    w[30:20] = pa;
                    w[33]    = 1'b1;
                    exp_q.push_back(w);
                end
                w        = IDLE_W;
                w[32]    = 1'b0;
                w[31]    = 1'b0;
                w[30:20] = pa;
                w[6]     = 1'b1;
                w[33]    = (kij > 0);
                w[34]    = relu_build && (kij == NKIJ - 1);
                exp_q.push_back(w);
            end
        end
        exp_q.push_back(IDLE_W);
    endtask

    // Starts a tile and compares every output word. Input j of the loop drives
    // state-cycle j and samples the word produced by state-cycle j-1.
    task automatic run_tile(input logic [10:0] kb, input logic [10:0] ab,
                            input logic [10:0] pb, input int stall_m,
                            input int stall_len, input int start_busy_at,
                            input int reset_at);
        int n_exp;
        int wi;
        exp_q.delete();
        obs.delete();
        done_at = -1;
        build_expected(kb, ab, pb, stall_m, stall_len);
        n_exp = exp_q.size();

        @(negedge clk);
        kernel_base = kb; act_base = ab; psum_base = pb;
        ofifo_valid = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        for (int j = 0; j <= n_exp + 1; j++) begin
            if (j >= 1) begin
                wi = j - 1;
                if (reset_at >= 0 && wi >= reset_at) begin
                    check($sformatf("rst_inst[%0d]", wi), inst, IDLE_W);
                    check($sformatf("rst_busy[%0d]", wi), busy, 0);
                    check($sformatf("rst_done[%0d]", wi), done, 0);
                    if (wi >= reset_at + 3) break;
                end else if (wi < n_exp) begin
                    obs.push_back(inst);
                    check($sformatf("inst[%0d]", wi), inst, exp_q.pop_front());
                    if (done === 1'b1 && done_at < 0) done_at = wi;
                    check($sformatf("done[%0d]", wi), done, 64'(wi == n_exp - 1));
                    if (wi < n_exp - 1) check($sformatf("busy[%0d]", wi), busy, 1);
                end else begin
                    check("busy_after_done", busy, 0);
                    check("done_after_done", done, 0);
                end
            end
            ofifo_valid = !(stall_len > 0 && j >= DRAIN0 + stall_m &&
                            j < DRAIN0 + stall_m + stall_len);
            if (j == start_busy_at) begin
                start = 1'b1;
                kernel_base = ~kb; act_base = ~ab; psum_base = ~pb;
            end else begin
                start = 1'b0;
            end
            reset = (reset_at >= 0 && j == reset_at);
            @(negedge clk);
        end
        reset       = 1'b0;
        start       = 1'b0;
        ofifo_valid = 1'b1;
    endtask

    initial begin
        int ones;
        int exp_relu;

        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
        kernel_base = '0; act_base = '0; psum_base = '0;
        repeat (3) @(negedge clk);
        check("reset_inst", inst, IDLE_W);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // start coincident with reset must be dropped
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; kernel_base = 11'd5;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_start_busy", busy, 0);
            check("rst_start_inst", inst, IDLE_W);
        end

        // reset during kij=0 EXEC, with an ignored start pulse while busy
        run_tile(11'd16, 11'd200, 11'd64, 0, 0, 20, 70);
        ones = 0;
        repeat (1500) begin
            @(negedge clk);
            if (done === 1'b1) ones++;
        end
        check("no_done_after_reset", ones, 0);
        check("idle_after_reset", inst, IDLE_W);

        // nominal tile
        run_tile(11'd0, 11'd100, 11'd0, 0, 0, -1, -1);
        check("first_x_cen_n", obs[0][19], 0);
        check("first_x_addr", obs[0][17:7], 0);
        check("first_l0_wr", obs[0][2], 0);
        check("second_l0_wr", obs[1][2], 1);
        check("done_latency", done_at, 1440);
        ones = 0;
        foreach (obs[i]) if (obs[i][34]) ones++;
`ifdef CORE_CTRL_RELU_EN
        exp_relu = LEN;
`else
        exp_relu = 0;
`endif
        check("relu_count", ones, exp_relu);

        // xmem wrap at 1024, pmem wrap at 2048, 5-cycle drain stall at m=10
        run_tile(11'd1020, 11'd1000, 11'd2040, 10, 5, -1, -1);
        for (int k = 0; k < COL; k++)
            check($sformatf("wrap_x_addr[%0d]", k), obs[k][17:7], (1020 + k) % 1024);
        ones = 0;
        foreach (obs[i]) if (obs[i][17]) ones++;
        check("bit17_never_set", ones, 0);
        for (int s = 0; s < 5; s++)
            check($sformatf("stall_idle[%0d]", s), obs[DRAIN0 + 10 + s], IDLE_W);
        check("stall_resume_addr", obs[DRAIN0 + 15][30:20], 11'd2050 - 11'd2048);
        check("done_latency_stall", done_at, 1445);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
